// File: rtl/neuron_membrane_update.sv
// Per-neuron, per-timestep membrane integrator: loads the decayed potential, sums one float
// weight per incoming spike, then fires or stores the new potential.

module addition_subtraction (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic [31:0] result,
  output logic        exception
);

  logic        sa, sb, sx, sy, exc_in;
  logic [7:0]  ea, eb, ex, ey, shamt;
  logic [23:0] ma, mb, mx, my;
  logic [26:0] mx_ext, my_ext, aligned, diff, norm;
  logic        sticky, round_up;
  logic [27:0] sum28;
  logic [4:0]  lzc;
  logic [9:0]  exp_n, exp_r;
  logic [24:0] mant25;
  logic [22:0] mant;

  // Denormal operands and underflowing results are flushed to zero; rounding is nearest-even.
  always_comb begin
    sa = a[31];
    sb = b[31] ^ op;
    ea = a[30:23];
    eb = b[30:23];
    ma = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    mb = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    exc_in = (ea == 8'hFF) || (eb == 8'hFF);

    if ({ea, ma} >= {eb, mb}) begin
      sx = sa; ex = ea; mx = ma;
      sy = sb; ey = eb; my = mb;
    end else begin
      sx = sb; ex = eb; mx = mb;
      sy = sa; ey = ea; my = ma;
    end

    shamt  = ex - ey;
    mx_ext = {mx, 3'b000};
    my_ext = {my, 3'b000};
    if (shamt >= 8'd27) begin
      aligned = 27'd0;
      sticky  = |my;
    end else begin
      aligned = my_ext >> shamt;
      sticky  = |(my_ext & ~({27{1'b1}} << shamt));
    end
    aligned[0] = aligned[0] | sticky;

    sum28 = {1'b0, mx_ext} + {1'b0, aligned};
    diff  = mx_ext - aligned;

    lzc = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (diff[i]) lzc = 5'(26 - i);
    end

    if (sx == sy) begin
      if (sum28[27]) begin
        norm  = {sum28[27:2], sum28[1] | sum28[0]};
        exp_n = {2'b00, ex} + 10'd1;
      end else begin
        norm  = sum28[26:0];
        exp_n = {2'b00, ex};
      end
    end else begin
      norm  = diff << lzc;
      exp_n = {2'b00, ex} - {5'd0, lzc};
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant25   = {1'b0, norm[26:3]} + 25'(round_up);
    if (mant25[24]) begin
      mant  = mant25[23:1];
      exp_r = exp_n + 10'd1;
    end else begin
      mant  = mant25[22:0];
      exp_r = exp_n;
    end

    exception = 1'b0;
    if (exc_in) begin
      exception = 1'b1;
      result    = {sx, 8'hFF, 23'd0};
    end else if (norm == 27'd0) begin
      result = {sx & sy, 31'd0};
    end else if (exp_r[9] || exp_r == 10'd0) begin
      result = {sx, 31'd0};
    end else if (exp_r >= 10'd255) begin
      exception = 1'b1;
      result    = {sx, 8'hFF, 23'd0};
    end else begin
      result = {sx, exp_r[7:0], mant};
    end
  end

endmodule

module neuron_membrane_update #(
  parameter int          REFRACT_STEPS = 2,
  parameter int          REFRACT_W     = 4,
  parameter logic [31:0] V_REST        = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [31:0] decayed_potential,
  input  logic        weight_valid,
  input  logic [31:0] weight_in,
  input  logic        weight_last,
  output logic        weight_ready,
  input  logic [31:0] threshold,
  input  logic [31:0] v_reset,
  output logic [31:0] membrane_potential,
  output logic        spike,
  output logic        done,
  output logic        busy,
  output logic        add_error
);

  typedef enum logic [1:0] {IDLE, LOAD, ACCUM, FIRE} state_t;

  state_t                 state, state_next;
  logic [31:0]            acc;
  logic [REFRACT_W-1:0]   refr_cnt;
  logic [31:0]            sum;
  logic                   sum_exc;
  logic                   beat_accept;
  logic                   fire_ok;

  addition_subtraction u_add (
    .a        (acc),
    .b        (weight_in),
    .op       (1'b0),
    .result   (sum),
    .exception(sum_exc)
  );

  // Float a >= b: signed zeros are equal, otherwise sign then magnitude decides.
  function automatic logic float_ge(input logic [31:0] x, input logic [31:0] y);
    if (x[30:0] == 31'd0 && y[30:0] == 31'd0) return 1'b1;
    if (x[31] != y[31]) return ~x[31];
    if (!x[31]) return x[30:0] >= y[30:0];
    return x[30:0] <= y[30:0];
  endfunction

  assign beat_accept = weight_valid && weight_ready;
  assign fire_ok     = float_ge(acc, threshold);

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    weight_ready = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE:  if (start) state_next = LOAD;
      LOAD:  state_next = ACCUM;
      ACCUM: begin
        weight_ready = 1'b1;
        if (weight_valid && weight_last) state_next = FIRE;
      end
      FIRE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Beats arriving during refractory are drained without touching the accumulator.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc                <= 32'd0;
      membrane_potential <= V_REST;
      refr_cnt           <= '0;
      spike              <= 1'b0;
      done               <= 1'b0;
      add_error          <= 1'b0;
    end else begin
      spike <= 1'b0;
      done  <= 1'b0;
      case (state)
        LOAD: acc <= decayed_potential;
        ACCUM: begin
          if (beat_accept && refr_cnt == '0) begin
            if (sum_exc) add_error <= 1'b1;
            else         acc       <= sum;
          end
        end
        FIRE: begin
          done <= 1'b1;
          if (refr_cnt != '0) begin
            refr_cnt           <= refr_cnt - REFRACT_W'(1);
            membrane_potential <= v_reset;
          end else if (fire_ok) begin
            membrane_potential <= v_reset;
            refr_cnt           <= REFRACT_W'(REFRACT_STEPS);
            spike              <= 1'b1;
          end else begin
            membrane_potential <= acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_membrane_update.sv
// Directed bench for neuron_membrane_update: hand-computed float sums, fire/refractory
// sequencing, latency, stalls, adder exceptions and reset behaviour.

module tb_neuron_membrane_update;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] decayedPotential;
  logic        weightValid;
  logic [31:0] weightIn;
  logic        weightLast;
  logic        weightReady;
  logic [31:0] threshold;
  logic [31:0] vReset;
  logic [31:0] membranePotential;
  logic        spike;
  logic        done;
  logic        busy;
  logic        addError;

  int errorCount = 0;
  int checkCount = 0;
  int cycleCount = 0;
  int latency;
  logic spikeSeen;

  neuron_membrane_update dut (
    .CLK               (clock),
    .RESET             (reset),
    .start             (start),
    .decayed_potential (decayedPotential),
    .weight_valid      (weightValid),
    .weight_in         (weightIn),
    .weight_last       (weightLast),
    .weight_ready      (weightReady),
    .threshold         (threshold),
    .v_reset           (vReset),
    .membrane_potential(membranePotential),
    .spike             (spike),
    .done              (done),
    .busy              (busy),
    .add_error         (addError)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic pulseReset();
    @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    weightValid = 1'b0;
    weightLast = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic waitReady();
    int cnt = 0;
    while (!weightReady && cnt < 10) begin
      @(negedge clock);
      cnt++;
    end
    if (!weightReady) checkOutput("readyTimeout", 32'(weightReady), 32'd1);
  endtask

  // One timestep: start pulse, up to two beats (first one optionally stalled), wait for done.
  task automatic applyStimulus(input logic [31:0] dec, input logic [31:0] w0, input logic [31:0] w1,
                               input int nBeats, input int gap, input logic [31:0] thr,
                               input logic [31:0] vres, input bit pokeStart,
                               output int lat, output logic spk);
    int startCycle;
    int cnt;
    @(negedge clock);
    start = 1'b1;
    decayedPotential = dec;
    threshold = thr;
    vReset = vres;
    startCycle = cycleCount;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < nBeats; i++) begin
      waitReady();
      if (i == 0 && gap > 0) begin
        weightValid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          if (pokeStart && g == 0) start = 1'b1;
          @(negedge clock);
          start = 1'b0;
        end
      end
      weightValid = 1'b1;
      weightIn = (i == 0) ? w0 : w1;
      weightLast = (i == nBeats - 1);
      @(negedge clock);
    end
    weightValid = 1'b0;
    weightLast = 1'b0;
    cnt = 0;
    while (!done && cnt < 10) begin
      @(negedge clock);
      cnt++;
    end
    checkOutput("doneSeen", 32'(done), 32'd1);
    lat = cycleCount - startCycle;
    spk = spike;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    decayedPotential = 32'd0;
    weightValid = 1'b0;
    weightIn = 32'd0;
    weightLast = 1'b0;
    threshold = 32'h40000000;
    vReset = 32'd0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("rstMembrane", membranePotential, 32'h00000000);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstReady", 32'(weightReady), 32'd0);
    checkOutput("rstDoneSpike", {30'd0, done, spike}, 32'd0);

    // 0.5 + 1.0 + 0.25 = 1.75, below 2.0
    applyStimulus(32'h3F000000, 32'h3F800000, 32'h3E800000, 2, 0, 32'h40000000, 32'd0, 1'b0, latency, spikeSeen);
    checkOutput("t2Membrane", membranePotential, 32'h3FE00000);
    checkOutput("t2Spike", 32'(spikeSeen), 32'd0);
    checkOutput("t2Latency", 32'(latency), 32'd5);

    // 1.5 + 1.0 = 2.5 fires
    applyStimulus(32'h3FC00000, 32'h3F800000, 32'd0, 1, 0, 32'h40000000, 32'd0, 1'b0, latency, spikeSeen);
    checkOutput("t3Spike", 32'(spikeSeen), 32'd1);
    checkOutput("t3Membrane", membranePotential, 32'h00000000);
    checkOutput("t3Latency", 32'(latency), 32'd4);
    @(negedge clock);
    checkOutput("t3SpikePulse", 32'(spike), 32'd0);

    // two refractory steps: large weights are drained, potential held at v_reset
    applyStimulus(32'h3F800000, 32'h40800000, 32'd0, 1, 0, 32'h40000000, 32'h3F000000, 1'b0, latency, spikeSeen);
    checkOutput("t4aSpike", 32'(spikeSeen), 32'd0);
    checkOutput("t4aMembrane", membranePotential, 32'h3F000000);
    applyStimulus(32'h3F800000, 32'h40800000, 32'd0, 1, 0, 32'h40000000, 32'h3E800000, 1'b0, latency, spikeSeen);
    checkOutput("t4bSpike", 32'(spikeSeen), 32'd0);
    checkOutput("t4bMembrane", membranePotential, 32'h3E800000);

    // third step integrates again; 1.0 + 1.0 == 2.0 fires on equality
    applyStimulus(32'h3F800000, 32'h3F800000, 32'd0, 1, 0, 32'h40000000, 32'd0, 1'b0, latency, spikeSeen);
    checkOutput("t5Spike", 32'(spikeSeen), 32'd1);
    checkOutput("t5Membrane", membranePotential, 32'h00000000);

    pulseReset();

    // 1.0 + (-3.0) = -2.0
    applyStimulus(32'h3F800000, 32'hC0400000, 32'd0, 1, 0, 32'h40000000, 32'd0, 1'b0, latency, spikeSeen);
    checkOutput("t6Membrane", membranePotential, 32'hC0000000);
    checkOutput("t6Spike", 32'(spikeSeen), 32'd0);
    checkOutput("t6Latency", 32'(latency), 32'd4);

    // same step with a three-cycle stall and a start pulse while busy
    applyStimulus(32'h3F800000, 32'hC0400000, 32'd0, 1, 3, 32'h40000000, 32'd0, 1'b1, latency, spikeSeen);
    checkOutput("t6gMembrane", membranePotential, 32'hC0000000);
    checkOutput("t6gSpike", 32'(spikeSeen), 32'd0);
    checkOutput("t6gLatency", 32'(latency), 32'd7);
    @(negedge clock);
    @(negedge clock);
    checkOutput("t6gNoQueuedStart", 32'(busy), 32'd0);

    // infinite weight raises the sticky error and is skipped: 1.0 + 0.5 = 1.5
    applyStimulus(32'h3F800000, 32'h7F800000, 32'h3F000000, 2, 0, 32'h40000000, 32'd0, 1'b0, latency, spikeSeen);
    checkOutput("errMembrane", membranePotential, 32'h3FC00000);
    checkOutput("errFlag", 32'(addError), 32'd1);
    checkOutput("errSpike", 32'(spikeSeen), 32'd0);

    // negative compare: -2.0 + 1.0 = -1.0 >= -3.0 fires
    applyStimulus(32'hC0000000, 32'h3F800000, 32'd0, 1, 0, 32'hC0400000, 32'h3F000000, 1'b0, latency, spikeSeen);
    checkOutput("negSpike", 32'(spikeSeen), 32'd1);
    checkOutput("negMembrane", membranePotential, 32'h3F000000);
    checkOutput("negErrSticky", 32'(addError), 32'd1);

    // reset in the middle of ACCUM after one beat
    @(negedge clock);
    start = 1'b1;
    decayedPotential = 32'h3F800000;
    @(negedge clock);
    start = 1'b0;
    waitReady();
    weightValid = 1'b1;
    weightIn = 32'h3F800000;
    weightLast = 1'b0;
    @(negedge clock);
    weightValid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("midRstReady", 32'(weightReady), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstMembrane", membranePotential, 32'h00000000);
    checkOutput("midRstError", 32'(addError), 32'd0);
    checkOutput("midRstDoneSpike", {30'd0, done, spike}, 32'd0);

    // refractory was cleared by reset, so this step integrates: 0 + 1.0
    applyStimulus(32'h00000000, 32'h3F800000, 32'd0, 1, 0, 32'h40000000, 32'h3F000000, 1'b0, latency, spikeSeen);
    checkOutput("postRstMembrane", membranePotential, 32'h3F800000);
    checkOutput("postRstSpike", 32'(spikeSeen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
